cpu_mem_arbiter: RTL
====================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter: DATA_FIRST, 1, when 1 the data port wins simultaneous requests, when 0 the instruction port wins.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: inst_sram_en in 1, inst_sram_wen in 4, inst_sram_addr in 32, inst_sram_wdata in 32: core instruction-side request.
REQ-005 SHALL have port: inst_sram_rdata  out  32  registered instruction read data.
REQ-006 SHALL have ports: data_sram_en in 1, data_sram_wen in 4, data_sram_addr in 32, data_sram_wdata in 32: core data-side request.
REQ-007 SHALL have port: data_sram_rdata  out  32  registered data read data.
REQ-008 SHALL have port: stallreq  out  1  freezes the core pipeline while a transaction is unfinished.
REQ-009 SHALL have ports: bus_req out 1, bus_wr out 1, bus_wstrb out 4, bus_addr out 32, bus_wdata out 32: single shared memory request.
REQ-010 SHALL have ports: bus_addr_ok in 1 (request accepted), bus_data_ok in 1 (response complete), bus_rdata in 32 (read data).

Function
REQ-011 SHALL implement FSM states IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
REQ-012 SHALL, in IDLE or DONE, capture each enabled port into its own pending flag plus its addr, wen and wdata registers.
REQ-013 SHALL, from IDLE/DONE with pending requests, enter D_REQ or I_REQ per DATA_FIRST; with no pending request it SHALL go to or stay in IDLE.
REQ-014 SHALL drive bus_req=1 only in D_REQ/I_REQ, and hold bus_addr, bus_wdata, bus_wstrb and bus_wr (= |wen) stable from the captured registers until bus_addr_ok=1.
REQ-015 SHALL move x_REQ->x_WAIT on bus_addr_ok=1 when bus_data_ok=0, and x_REQ->next directly when bus_addr_ok=1 and bus_data_ok=1 in the same cycle.
REQ-016 SHALL, on bus_data_ok in x_WAIT/x_REQ, latch bus_rdata into the matching rdata register if the access is a read, clear that pending flag, then go to the other port's REQ state if it is pending, else to DONE.
REQ-017 SHALL leave rdata registers unchanged on writes and SHALL hold rdata until the next completed read of the same port.
REQ-018 SHALL drive stallreq combinationally: 1 whenever any pending flag is set, or when IDLE/DONE sees a new enable; 0 in DONE and in IDLE with no enable.
REQ-019 SHALL spend exactly one cycle in DONE with stallreq=0, so the core advances once and observes both rdata values.
REQ-020 SHALL give a read with bus_addr_ok and bus_data_ok in consecutive cycles a total core stall of 3 cycles (IDLE detect, REQ, WAIT); DONE follows.
REQ-021 SHALL ignore bus_data_ok in IDLE, DONE and x_REQ-before-accept, and SHALL ignore core enables while any pending flag is set.
REQ-022 SHALL treat wen=4'b0000 as a read and any nonzero wen as a write with bus_wstrb=wen.

Reset
REQ-023 SHALL on rst=1 immediately force IDLE, clear pending flags, and drive bus_req=0, stallreq=0, inst_sram_rdata=0 and data_sram_rdata=0.
REQ-024 SHALL abandon an in-flight bus transaction on reset mid-operation, and SHALL ignore any bus_data_ok arriving in the first cycle after reset release.

Structure
REQ-025 SHALL place FSM state encodings and the stall-bus width constant in the shared defines header.
REQ-026 SHALL be a single module with no sub-modules; the core top instantiates it and ORs stallreq into the CTRL stall request.

Verification
REQ-027 SHALL pass: inst read 0xBFC00000, bus answers addr_ok at +1 and data_ok at +2 with 0x3C1D0001 -> inst_sram_rdata=0x3C1D0001, stallreq high exactly 3 cycles.
REQ-028 SHALL pass: simultaneous inst read and data write (addr 0x80000010, wen 4'b1111, wdata 0xDEADBEEF), DATA_FIRST=1 -> the data write is issued first, then the inst read, stallreq falls only in DONE.
REQ-029 SHALL pass: sb with wen=4'b0100 -> bus_wstrb=4'b0100, bus_wr=1, data_sram_rdata unchanged.
REQ-030 SHALL pass: addr_ok and data_ok asserted in the same cycle -> REQ goes straight to DONE, stall of 2 cycles.
REQ-031 SHALL pass: bus_addr_ok held low 5 cycles -> bus_addr and bus_req stay stable throughout, stallreq stays 1.
REQ-032 SHALL pass: rst asserted during D_WAIT -> IDLE, all outputs 0 on the same edge, and a following late bus_data_ok is ignored.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared state encodings and constants for the cpu/memory arbiter
package cpu_mem_arbiter_pkg;

  // Arbiter FSM states: x_REQ presents the request, x_WAIT waits for the response
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } arb_state_e;

  // Width of the core's CTRL stall vector that stallreq is ORed into
  localparam int STALL_W = 6;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - merges core inst/data sram ports onto one handshaked memory bus
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,

  output logic        stallreq,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arb_state_e  state_q, state_d;
  logic        inst_pend_q, inst_pend_d;
  logic        data_pend_q, data_pend_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [3:0]  inst_wen_q, inst_wen_d;
  logic [31:0] inst_wdata_q, inst_wdata_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [3:0]  data_wen_q, data_wen_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        in_d_req;
  logic        in_i_req;
  logic        data_done;
  logic        inst_done;

  // Response completion: same-cycle accept+response in REQ, or response in WAIT
  always_comb begin
    in_d_req  = (state_q == D_REQ);
    in_i_req  = (state_q == I_REQ);
    data_done = (in_d_req && bus_addr_ok && bus_data_ok) ||
                ((state_q == D_WAIT) && bus_data_ok);
    inst_done = (in_i_req && bus_addr_ok && bus_data_ok) ||
                ((state_q == I_WAIT) && bus_data_ok);
  end

  // Next-state, request capture and read-data latching
  always_comb begin
    state_d      = state_q;
    inst_pend_d  = inst_pend_q;
    data_pend_d  = data_pend_q;
    inst_addr_d  = inst_addr_q;
    inst_wen_d   = inst_wen_q;
    inst_wdata_d = inst_wdata_q;
    data_addr_d  = data_addr_q;
    data_wen_d   = data_wen_q;
    data_wdata_d = data_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE, DONE: begin
        // Nothing is pending here, so every enable is a fresh request
        inst_pend_d = inst_sram_en;
        data_pend_d = data_sram_en;
        if (inst_sram_en) begin
          inst_addr_d  = inst_sram_addr;
          inst_wen_d   = inst_sram_wen;
          inst_wdata_d = inst_sram_wdata;
        end
        if (data_sram_en) begin
          data_addr_d  = data_sram_addr;
          data_wen_d   = data_sram_wen;
          data_wdata_d = data_sram_wdata;
        end
        if (data_sram_en && (DATA_FIRST || !inst_sram_en)) begin
          state_d = D_REQ;
        end else if (inst_sram_en) begin
          state_d = I_REQ;
        end else begin
          state_d = IDLE;
        end
      end

      D_REQ, D_WAIT: begin
        if (data_done) begin
          if (data_wen_q == 4'b0000) begin
            data_rdata_d = bus_rdata;
          end
          data_pend_d = 1'b0;
          state_d     = inst_pend_q ? I_REQ : DONE;
        end else if (in_d_req && bus_addr_ok) begin
          state_d = D_WAIT;
        end
      end

      I_REQ, I_WAIT: begin
        if (inst_done) begin
          if (inst_wen_q == 4'b0000) begin
            inst_rdata_d = bus_rdata;
          end
          inst_pend_d = 1'b0;
          state_d     = data_pend_q ? D_REQ : DONE;
        end else if (in_i_req && bus_addr_ok) begin
          state_d = I_WAIT;
        end
      end

      default: begin
        state_d     = IDLE;
        inst_pend_d = 1'b0;
        data_pend_d = 1'b0;
      end
    endcase
  end

  // State and captured-request registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      inst_addr_q  <= '0;
      inst_wen_q   <= '0;
      inst_wdata_q <= '0;
      data_addr_q  <= '0;
      data_wen_q   <= '0;
      data_wdata_q <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_pend_q  <= inst_pend_d;
      data_pend_q  <= data_pend_d;
      inst_addr_q  <= inst_addr_d;
      inst_wen_q   <= inst_wen_d;
      inst_wdata_q <= inst_wdata_d;
      data_addr_q  <= data_addr_d;
      data_wen_q   <= data_wen_d;
      data_wdata_q <= data_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Bus request is driven straight from the captured registers so it holds until accepted
  always_comb begin
    bus_req   = in_d_req || in_i_req;
    bus_addr  = in_d_req ? data_addr_q  : (in_i_req ? inst_addr_q  : 32'h0);
    bus_wdata = in_d_req ? data_wdata_q : (in_i_req ? inst_wdata_q : 32'h0);
    bus_wstrb = in_d_req ? data_wen_q   : (in_i_req ? inst_wen_q   : 4'h0);
    bus_wr    = |bus_wstrb;
  end

  // Stall while anything is pending, or when IDLE sees a new request; DONE always releases
  always_comb begin
    stallreq = !rst &&
               (inst_pend_q || data_pend_q ||
                ((state_q == IDLE) && (inst_sram_en || data_sram_en)));
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

endmodule
